// File: rtl/inv_sub_bytes_serial_pkg.sv
// Shared AES definitions for the inverse cipher datapath: state type,
// FSM encoding, byte slicing and the GF(2^8) arithmetic used by the S-boxes.
package inv_sub_bytes_serial_pkg;

  localparam int AES_NB_BYTES = 16;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } fsm_state_t;

  // Byte i of the state in FIPS-197 order (byte 0 is the most significant).
  function automatic logic [7:0] state_byte(input aes_state_t s, input int idx);
    return s[127-8*idx -: 8];
  endfunction

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  // The forward S-box uses the same core, only the affine step differs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_serial_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine transform followed by
// the GF(2^8) inversion core shared with the forward S-box.
module inv_sbox
  import inv_sub_bytes_serial_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] affine_out;

  // Inverse affine map: b_i = y_(i+2) ^ y_(i+5) ^ y_(i+7) ^ 0x05_i, then invert.
  always_comb begin
    affine_out = 8'h00;
    for (int i = 0; i < 8; i++) begin
      affine_out[i] = din[(i+2)%8] ^ din[(i+5)%8] ^ din[(i+7)%8];
    end
    affine_out = affine_out ^ 8'h05;
    dout = gf_inv(affine_out);
  end

endmodule

// File: rtl/inv_sub_bytes_serial.sv
// Byte-serial InvSubBytes engine: takes a 128-bit state, substitutes LANES
// bytes per cycle in place, and returns the result over a valid/ready port.
module inv_sub_bytes_serial
  import inv_sub_bytes_serial_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int STEPS = AES_NB_BYTES / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $fatal(1, "inv_sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_state_t  state;
  logic [CW-1:0] cnt;
  aes_state_t  work;
  aes_state_t  work_next;
  int          base;
  logic [7:0]  sbox_in  [LANES];
  logic [7:0]  sbox_out [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .din  (sbox_in[g]),
      .dout (sbox_out[g])
    );
  end

  // Select the group of bytes addressed by the counter for the S-box lanes.
  always_comb begin
    base = int'(cnt) * LANES;
    for (int l = 0; l < LANES; l++) begin
      sbox_in[l] = state_byte(work, base + l);
    end
  end

  // Write the substituted bytes back into their original positions.
  always_comb begin
    work_next = work;
    for (int l = 0; l < LANES; l++) begin
      work_next[127-8*(int'(cnt)*LANES + l) -: 8] = sbox_out[l];
    end
  end

  assign out_data = work;

  // Control FSM with registered handshake/status outputs and the working register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          work <= work_next;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Scoreboard bench for inv_sub_bytes_serial: instance 0 (LANES=1) is checked
// by a queue-based monitor, instances 1..4 (LANES=2,4,8,16) by direct latency
// and data checks.
module tb_inv_sub_bytes_serial;

  localparam logic [127:0] VEC_IN  = 128'h637C777BF26B6FC53001672BFED7AB76;
  localparam logic [127:0] VEC_OUT = 128'h000102030405060708090A0B0C0D0E0F;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } sb_item_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic         in_valid_v  [5];
  logic         in_ready_v  [5];
  logic [127:0] out_data_v  [5];
  logic         out_valid_v [5];
  logic         out_ready_v [5];
  logic         busy_v      [5];

  int errors = 0;
  int checks = 0;
  bit rand_en = 0;
  sb_item_t sb_q[$];
  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_serial #(.LANES(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .out_data  (out_data_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .busy      (busy_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: multiply, brute-force inverse, forward S-box.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_fwd(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] r;
    for (int y = 1; y < 256; y++) begin
      if (m_mul(x, 8'(y)) == 8'h01) v = 8'(y);
    end
    for (int i = 0; i < 8; i++) begin
      r[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
    end
    return r;
  endfunction

  function automatic logic [127:0] model_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tbl[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fwd_tbl[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_en) out_ready_v[0] = 1'($urandom_range(0, 1));
  endtask

  // Offer a state to instance k; returns right after the accept edge.
  task automatic apply_stimulus(input int k, input logic [127:0] data, input logic [127:0] exp,
                                input bit push, input bit hold);
    bit acc;
    bit ok = 0;
    int guard = 0;
    in_data = data;
    in_valid_v[k] = 1'b1;
    while (!ok && guard < 200) begin
      acc = in_ready_v[k];
      step();
      guard++;
      if (acc) ok = 1;
    end
    if (!hold) in_valid_v[k] = 1'b0;
    if (ok && push) sb_q.push_back('{din: data, exp: exp});
    if (!ok) begin
      errors++;
      checks++;
      $display("[TB] FAIL accept_timeout: lane instance %0d never took the state", k);
    end
  endtask

  // Edges counted from the accept edge (inclusive) to the out_valid rising edge.
  task automatic wait_valid(input int k, output int lat);
    lat = 1;
    while (!out_valid_v[k] && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 5000) begin
      step();
      guard++;
    end
    check_output("scoreboard_empty", 128'(sb_q.size()), 128'd0);
  endtask

  // Monitor: compare every output handshake of instance 0 against the queue.
  always @(negedge clk) begin
    sb_item_t item;
    if (rst_n && out_valid_v[0] && out_ready_v[0]) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %h, expected no output", out_data_v[0]);
      end else begin
        item = sb_q.pop_front();
        check_output("out_data", out_data_v[0], item.exp);
        check_output("fwd_roundtrip", model_fwd(out_data_v[0]), item.din);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [127:0] d;

    for (int x = 0; x < 256; x++) fwd_tbl[x] = m_fwd(8'(x));
    for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);

    rst_n   = 1'b0;
    in_data = '0;
    for (int k = 0; k < 5; k++) begin
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b1;
    end
    repeat (3) step();
    check_output("reset_in_ready",  128'(in_ready_v[0]),  128'd1);
    check_output("reset_out_valid", 128'(out_valid_v[0]), 128'd0);
    check_output("reset_busy",      128'(busy_v[0]),      128'd0);
    check_output("reset_out_data",  out_data_v[0],        128'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] known-answer vector, LANES=1");
    apply_stimulus(0, VEC_IN, VEC_OUT, 1, 0);
    wait_valid(0, lat);
    check_output("latency_lanes1", 128'(lat), 128'd17);
    step();
    check_output("in_ready_after_out", 128'(in_ready_v[0]), 128'd1);
    check_output("out_valid_after_out", 128'(out_valid_v[0]), 128'd0);

    $display("[TB] backpressure hold");
    out_ready_v[0] = 1'b0;
    apply_stimulus(0, {16{8'h63}}, 128'd0, 1, 0);
    wait_valid(0, lat);
    for (int c = 0; c < 10; c++) begin
      check_output("hold_out_valid", 128'(out_valid_v[0]), 128'd1);
      check_output("hold_out_data",  out_data_v[0],        128'd0);
      check_output("hold_in_ready",  128'(in_ready_v[0]),  128'd0);
      step();
    end
    out_ready_v[0] = 1'b1;
    step();
    check_output("release_out_valid", 128'(out_valid_v[0]), 128'd0);
    check_output("release_in_ready",  128'(in_ready_v[0]),  128'd1);

    $display("[TB] all 256 byte values");
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'(16*j + i);
      apply_stimulus(0, d, model_inv(d), 1, 0);
    end
    drain();

    $display("[TB] reset during BUSY");
    apply_stimulus(0, VEC_IN, '0, 0, 0);
    repeat (7) step();
    check_output("mid_busy", 128'(busy_v[0]), 128'd1);
    rst_n = 1'b0;
    step();
    check_output("abort_in_ready",  128'(in_ready_v[0]),  128'd1);
    check_output("abort_out_valid", 128'(out_valid_v[0]), 128'd0);
    check_output("abort_busy",      128'(busy_v[0]),      128'd0);
    check_output("abort_out_data",  out_data_v[0],        128'd0);
    rst_n = 1'b1;
    step();
    apply_stimulus(0, {16{8'hED}}, {16{8'h53}}, 1, 0);
    drain();

    $display("[TB] LANES sweep");
    for (int k = 1; k < 5; k++) begin
      apply_stimulus(k, VEC_IN, '0, 0, 0);
      wait_valid(k, lat);
      check_output($sformatf("latency_lanes%0d", 1 << k), 128'(lat), 128'((16 >> k) + 1));
      check_output($sformatf("out_data_lanes%0d", 1 << k), out_data_v[k], VEC_OUT);
      step();
    end

    $display("[TB] continuous in_valid with random out_ready");
    rand_en = 1;
    for (int n = 0; n < 100; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(0, d, model_inv(d), 1, 1);
    end
    in_valid_v[0] = 1'b0;
    rand_en = 0;
    out_ready_v[0] = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
